// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// A digit code is {blank, dp, dash, val[3:0]} as consumed by the external decoder.
package sevenseg_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic       dash;
    logic [3:0] val;
  } seg_code_t;

  localparam logic [6:0] SEG_BLANK = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0010000;

endpackage

// File: rtl/sevenseg_lzmask.sv
// Leading-zero blanking and minus-sign placement for the latched display value.
// Purely combinational; digit 0 is never blanked and never carries the dash.
module sevenseg_lzmask
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS = 8
) (
  input  logic [4*NDIGITS-1:0] value_i,
  input  logic                 lz_blank_i,
  input  logic                 neg_i,
  output logic [NDIGITS-1:0]   blank_mask_o,
  output logic [NDIGITS-1:0]   dash_onehot_o,
  output logic                 ovf_o
);

  localparam int IW = $clog2(NDIGITS);

  logic [IW-1:0] msd;

  // Ascending scan, so the highest nonzero nibble is the last one to win.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      if (value_i[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  always_comb begin
    blank_mask_o  = '0;
    dash_onehot_o = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      blank_mask_o[i]  = lz_blank_i && (IW'(i) > msd);
      dash_onehot_o[i] = neg_i && lz_blank_i && (IW'(i) == (msd + IW'(1)));
    end
    ovf_o = neg_i && ((msd == IW'(NDIGITS - 1)) || !lz_blank_i);
  end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Time-multiplexed common-anode display driver: double-buffered value capture,
// per-slot guard interval with all anodes off, and registered digit code/anode outputs.
module sevenseg_scan_ctl
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS   = 8,
  parameter int TICKDIV   = 25000,
  parameter int GUARD_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [4*NDIGITS-1:0] value_i,
  input  logic [NDIGITS-1:0]   dp_mask_i,
  input  logic                 neg_i,
  input  logic                 lz_blank_i,
  output logic                 pending_o,
  output logic                 neg_ovf_o,
  output logic [6:0]           d_o,
  output logic [NDIGITS-1:0]   an_n_o
);

  localparam int PW = $clog2(TICKDIV);
  localparam int IW = $clog2(NDIGITS);

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   sh_value_q, sh_value_d, act_value_q, act_value_d;
  logic [NDIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                   sh_neg_q, sh_neg_d, act_neg_q, act_neg_d;
  logic                   sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic                   pending_q, pending_d;
  logic                   neg_ovf_q, neg_ovf_d;
  seg_code_t              seg_q, seg_d;
  logic [NDIGITS-1:0]     an_n_q, an_n_d;

  logic                   slot_end;
  logic                   frame_end;
  logic [NDIGITS-1:0]     blank_mask;
  logic [NDIGITS-1:0]     dash_onehot;
  logic                   ovf;

  sevenseg_lzmask #(
    .NDIGITS (NDIGITS)
  ) u_lzmask (
    .value_i       (act_value_q),
    .lz_blank_i    (act_lz_q),
    .neg_i         (act_neg_q),
    .blank_mask_o  (blank_mask),
    .dash_onehot_o (dash_onehot),
    .ovf_o         (ovf)
  );

  always_comb begin
    slot_end  = (pcnt_q == PW'(TICKDIV - 1));
    frame_end = slot_end && (idx_q == IW'(NDIGITS - 1));

    pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);

    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_neg_d   = sh_neg_q;
    sh_lz_d    = sh_lz_q;
    if (load_i) begin
      sh_value_d = value_i;
      sh_dp_d    = dp_mask_i;
      sh_neg_d   = neg_i;
      sh_lz_d    = lz_blank_i;
    end

    // Active takes the pre-load shadow, so a load on the boundary stays pending.
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_neg_d   = act_neg_q;
    act_lz_d    = act_lz_q;
    pending_d   = pending_q;
    if (frame_end) begin
      act_value_d = sh_value_q;
      act_dp_d    = sh_dp_q;
      act_neg_d   = sh_neg_q;
      act_lz_d    = sh_lz_q;
      pending_d   = 1'b0;
    end
    if (load_i) pending_d = 1'b1;

    neg_ovf_d = ovf;

    seg_d  = seg_code_t'(SEG_BLANK);
    an_n_d = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        if (dash_onehot[i]) begin
          seg_d = seg_code_t'(SEG_DASH);
        end else if (blank_mask[i]) begin
          seg_d = seg_code_t'(SEG_BLANK);
        end else begin
          seg_d.blank = 1'b0;
          seg_d.dp    = act_dp_q[i];
          seg_d.dash  = 1'b0;
          seg_d.val   = act_value_q[4*i +: 4];
        end
        an_n_d[i] = (pcnt_q < PW'(GUARD_CYC));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_neg_q    <= 1'b0;
      sh_lz_q     <= 1'b0;
      act_value_q <= '0;
      act_dp_q    <= '0;
      act_neg_q   <= 1'b0;
      act_lz_q    <= 1'b0;
      pending_q   <= 1'b0;
      neg_ovf_q   <= 1'b0;
      seg_q       <= seg_code_t'(SEG_BLANK);
      an_n_q      <= '1;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      sh_value_q  <= sh_value_d;
      sh_dp_q     <= sh_dp_d;
      sh_neg_q    <= sh_neg_d;
      sh_lz_q     <= sh_lz_d;
      act_value_q <= act_value_d;
      act_dp_q    <= act_dp_d;
      act_neg_q   <= act_neg_d;
      act_lz_q    <= act_lz_d;
      pending_q   <= pending_d;
      neg_ovf_q   <= neg_ovf_d;
      seg_q       <= seg_d;
      an_n_q      <= an_n_d;
    end
  end

  assign pending_o = pending_q;
  assign neg_ovf_o = neg_ovf_q;
  assign d_o       = seg_q;
  assign an_n_o    = an_n_q;

endmodule
